// File: rtl/gps_frame_tx.sv
// Snapshots a settled 224-bit GPS record and streams it as a framed byte sequence.
// Define GPS_FRAME_CKSUM_EN to append a modulo-256 checksum byte after the status byte.
module gps_frame_tx #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned HEARTBEAT     = 1000000,
  parameter logic [7:0]  SYNC0         = 8'hA5,
  parameter logic [7:0]  SYNC1         = 8'h5A
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [223:0] gps_data,
  input  logic         gps_error,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic [15:0]  frame_count
);

  localparam int unsigned HB_W = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
  localparam logic [HB_W-1:0] HB_MAX = (HEARTBEAT > 0) ? HB_W'(HEARTBEAT - 1) : '0;
  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC_A, S_SYNC_B, S_PAYLOAD, S_STATUS, S_CKSUM
  } state_t;

  state_t state_q, state_d;
  logic [223:0] samp_q, samp_d, snap_q, snap_d;
  logic [3:0] stab_q, stab_d;
  logic [HB_W-1:0] hb_q, hb_d;
  logic [4:0] idx_q, idx_d;
  logic err_q, err_d, hbf_q, hbf_d;
  logic [15:0] fc_q, fc_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_valid_q, tx_valid_d, busy_q, busy_d;
`ifdef GPS_FRAME_CKSUM_EN
  logic [7:0] cks_q, cks_d;
`endif

  logic accept_s, stable_s, change_s, hb_hit_s, trig_s, frame_end_s;

  function automatic logic [7:0] rec_byte(input logic [223:0] rec, input logic [4:0] k);
    rec_byte = rec[(9'd223 - {1'b0, k, 3'b000}) -: 8];
  endfunction

  assign accept_s = tx_valid_q & tx_ready;
  assign stable_s = (stab_q == STAB_MAX);
  assign change_s = (samp_q != snap_q);
  assign hb_hit_s = (HEARTBEAT != 0) && (hb_q == HB_MAX);
  // Change wins over heartbeat; the status flag marks heartbeat-only frames.
  assign trig_s   = (state_q == S_IDLE) & stable_s & (change_s | hb_hit_s);

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      samp_q     <= '0;
      snap_q     <= '0;
      stab_q     <= 4'd0;
      hb_q       <= '0;
      idx_q      <= 5'd0;
      err_q      <= 1'b0;
      hbf_q      <= 1'b0;
      fc_q       <= 16'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef GPS_FRAME_CKSUM_EN
      cks_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      snap_q     <= snap_d;
      stab_q     <= stab_d;
      hb_q       <= hb_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      hbf_q      <= hbf_d;
      fc_q       <= fc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
`ifdef GPS_FRAME_CKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  // Next-state logic: every transition out of a byte state waits for an accept.
  always_comb begin
    state_d     = state_q;
    frame_end_s = 1'b0;
    case (state_q)
      S_IDLE:    if (trig_s) state_d = S_SYNC_A; else state_d = S_IDLE;
      S_SYNC_A:  if (accept_s) state_d = S_SYNC_B; else state_d = S_SYNC_A;
      S_SYNC_B:  if (accept_s) state_d = S_PAYLOAD; else state_d = S_SYNC_B;
      S_PAYLOAD: if (accept_s && idx_q == 5'd27) state_d = S_STATUS; else state_d = S_PAYLOAD;
      S_STATUS: begin
        if (accept_s) begin
`ifdef GPS_FRAME_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d     = S_IDLE;
          frame_end_s = 1'b1;
`endif
        end else begin
          state_d = S_STATUS;
        end
      end
`ifdef GPS_FRAME_CKSUM_EN
      S_CKSUM: begin
        if (accept_s) begin
          state_d     = S_IDLE;
          frame_end_s = 1'b1;
        end else begin
          state_d = S_CKSUM;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Sampler, capture, heartbeat timer, byte index and frame counter.
  always_comb begin
    samp_d = gps_data;
    if (gps_data != samp_q) stab_d = 4'd0;
    else if (stab_q != STAB_MAX) stab_d = stab_q + 4'd1;
    else stab_d = stab_q;

    if (trig_s) begin
      snap_d = samp_q;
      err_d  = gps_error;
      hbf_d  = hb_hit_s & ~change_s;
      hb_d   = '0;
    end else begin
      snap_d = snap_q;
      err_d  = err_q;
      hbf_d  = hbf_q;
      if (state_q == S_IDLE && hb_q != HB_MAX) hb_d = hb_q + HB_W'(1);
      else hb_d = hb_q;
    end

    if (frame_end_s) idx_d = 5'd0;
    else if (accept_s && state_q == S_PAYLOAD && idx_q != 5'd27) idx_d = idx_q + 5'd1;
    else idx_d = idx_q;

    if (frame_end_s) fc_d = fc_q + 16'd1;
    else fc_d = fc_q;

`ifdef GPS_FRAME_CKSUM_EN
    // tx_data_q is exactly the byte being accepted this cycle.
    if (trig_s) cks_d = 8'h00;
    else if (accept_s && (state_q == S_PAYLOAD || state_q == S_STATUS)) cks_d = cks_q + tx_data_q;
    else cks_d = cks_q;
`endif
  end

  // Output logic: outputs are registered from next-state values, so they hold while stalled.
  always_comb begin
    tx_valid_d = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_SYNC_A:  tx_data_d = SYNC0;
      S_SYNC_B:  tx_data_d = SYNC1;
      S_PAYLOAD: tx_data_d = rec_byte(snap_d, idx_d);
      S_STATUS:  tx_data_d = {err_d, 6'b000000, hbf_d};
`ifdef GPS_FRAME_CKSUM_EN
      S_CKSUM:   tx_data_d = cks_d;
`endif
      default:   tx_data_d = 8'h00;
    endcase
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_gps_frame_tx.sv
// Directed bench for gps_frame_tx: table of frames plus hand-written timing sequences.
// Frame length follows GPS_FRAME_CKSUM_EN.
module tb_gps_frame_tx;
`ifdef GPS_FRAME_CKSUM_EN
  localparam int FL = 32;
`else
  localparam int FL = 31;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [223:0] gps_data = '0;
  logic gps_error = 1'b0;
  logic tx_ready = 1'b1;
  logic [7:0] tx_data, tx_data0;
  logic tx_valid, tx_valid0, busy, busy0;
  logic [15:0] frame_count, frame_count0;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_fc = 0;
  bit watch0 = 1'b0;
  int v0cnt = 0;
  logic [7:0] got [32];

  typedef struct {
    logic [223:0] data;
    logic         err;
    bit           rnd;
    logic [7:0]   st;
  } vec_t;

  always #5 clock = ~clock;

  gps_frame_tx #(.STABLE_CYCLES(4), .HEARTBEAT(50)) dut (
    .clock(clock), .reset(reset), .gps_data(gps_data), .gps_error(gps_error),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_count(frame_count));

  gps_frame_tx #(.STABLE_CYCLES(4), .HEARTBEAT(0)) dut0 (
    .clock(clock), .reset(reset), .gps_data(gps_data), .gps_error(gps_error),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
    .busy(busy0), .frame_count(frame_count0));

  always @(negedge clock) if (watch0 && tx_valid0) v0cnt <= v0cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [223:0] mk(input logic [7:0] base, input logic [7:0] step);
    logic [223:0] r;
    r = '0;
    for (int k = 0; k < 28; k++) r[223-8*k -: 8] = base + step * 8'(k);
    return r;
  endfunction

  localparam logic [223:0] REC_A = mk(8'h10, 8'h02);
  localparam logic [223:0] REC_B = mk(8'h20, 8'h05);
  localparam logic [223:0] REC_C = mk(8'h33, 8'h11);
  localparam logic [223:0] REC_D = mk(8'h44, 8'h01);
  localparam logic [223:0] REC_E = mk(8'h55, 8'h07);
  localparam logic [223:0] REC_R = mk(8'h80, 8'h03);

  // Waits for a frame, then accepts stop_n bytes comparing each to the expected frame.
  task automatic get_frame(input logic [223:0] d, input logic [7:0] st, input bit rnd,
                           input int stop_n, input bit mid, output int waited);
    logic [7:0] exp_b [32];
    logic [7:0] sum, held;
    int n, guard;
    bit stalled;
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h5A;
    for (int k = 0; k < 28; k++) exp_b[2+k] = d[223-8*k -: 8];
    exp_b[30] = st;
    sum = 8'h00;
    for (int k = 2; k < 31; k++) sum = sum + exp_b[k];
    exp_b[31] = sum;
    waited = 0;
    @(negedge clock);
    while (!tx_valid && waited < 200) begin
      waited++;
      @(negedge clock);
    end
    if (!tx_valid) begin
      check("start_timeout", 32'(tx_valid), 32'd1);
      return;
    end
    n = 0;
    guard = 0;
    stalled = 1'b0;
    held = 8'h00;
    while (n < stop_n) begin
      guard++;
      if (guard > 2000) begin
        check("frame_timeout", 32'(n), 32'(stop_n));
        return;
      end
      if (stalled) check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
      if (!tx_valid) begin
        check("valid_drop", 32'(n), 32'(stop_n));
        return;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_ready) begin
        check($sformatf("byte%0d", n), 32'(tx_data), 32'(exp_b[n]));
        got[n] = tx_data;
        n++;
        stalled = 1'b0;
        if (mid && n == 5) gps_data = REC_D;
        if (mid && n == 10) begin
          gps_data  = REC_E;
          gps_error = 1'b1;
        end
      end else begin
        stalled = 1'b1;
        held = tx_data;
      end
      if (n < stop_n) @(negedge clock);
    end
  endtask

  // Lets the final accept happen, then checks the end-of-frame state.
  task automatic post_frame();
    @(posedge clock);
    #1;
    exp_fc++;
    check("frame_count", 32'(frame_count), 32'(exp_fc));
    check("busy_end", 32'(busy), 32'd0);
    check("valid_end", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    vec_t tbl [3];
    int w, vcnt;
    tbl[0] = '{mk(8'h01, 8'h01), 1'b0, 1'b0, 8'h00};
    tbl[1] = '{mk(8'hF0, 8'hFD), 1'b1, 1'b1, 8'h80};
    tbl[2] = '{mk(8'h01, 8'h01), 1'b0, 1'b1, 8'h00};

    repeat (3) @(negedge clock);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      gps_data  = tbl[i].data;
      gps_error = tbl[i].err;
      get_frame(tbl[i].data, tbl[i].st, tbl[i].rnd, FL, 1'b0, w);
      if (i > 0) check("idle_gap", 32'(w >= 1), 32'd1);
      post_frame();
`ifdef GPS_FRAME_CKSUM_EN
      if (i == 0) check("cksum_first", 32'(got[31]), 32'h96);
`endif
    end

    // Unchanged record: heartbeat frame after 50 idle cycles.
    get_frame(tbl[2].data, 8'h01, 1'b0, FL, 1'b0, w);
    check("hb_gap", 32'(w), 32'd50);
    post_frame();

    // Record toggling every 2 cycles never settles.
    vcnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      vcnt += int'(tx_valid);
      if (i % 2 == 0) gps_data = (i % 4 == 0) ? REC_A : REC_B;
    end
    check("toggle_quiet", 32'(vcnt), 32'd0);
    get_frame(REC_A, 8'h00, 1'b0, FL, 1'b0, w);
    check("settle_latency", 32'(w), 32'd5);
    post_frame();

    // Two changes mid-frame: one follow-up carrying the last value and the error flag.
    gps_data = REC_C;
    gps_error = 1'b0;
    get_frame(REC_C, 8'h00, 1'b1, FL, 1'b1, w);
    post_frame();
    get_frame(REC_E, 8'h80, 1'b0, FL, 1'b0, w);
    check("followup_gap", 32'(w), 32'd1);
    post_frame();
    gps_error = 1'b0;
    watch0 = 1'b1;
    get_frame(REC_E, 8'h01, 1'b0, FL, 1'b0, w);
    check("hb_gap2", 32'(w), 32'd50);
    post_frame();
    repeat (40) @(negedge clock);
    watch0 = 1'b0;
    check("nohb_valid", 32'(v0cnt), 32'd0);
    check("nohb_count", 32'(frame_count0), 32'(exp_fc - 2));

    // Reset in the middle of the payload abandons the frame.
    gps_data = REC_R;
    get_frame(REC_R, 8'h00, 1'b0, 12, 1'b0, w);
    @(posedge clock);
    #2;
    check("byte10_shown", 32'(tx_data), 32'h9E);
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(tx_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(frame_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_fc = 0;
    get_frame(REC_R, 8'h00, 1'b0, FL, 1'b0, w);
    post_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
